drive_move_sequencer: RTL and testbench

- Autonomous move controller that drives the vehicle command port (CMD / DATA / sipo_done strobe) on its own.
- On start, it writes duty and direction to all four motors, then polls one wheel's pulse-count distance at a fixed interval.
- When the target is reached, or on abort or timeout, it writes zero duty to all four motors.
- It sits beside the serial link and owns the command port while busy; the top level muxes the port to this block whenever busy=1.

---
 rtl/drive_move_sequencer_if.sv | 28 ++
 rtl/drive_move_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_drive_move_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/drive_move_sequencer_if.sv
// rtl/drive_move_sequencer_if.sv - vehicle command port between the move sequencer and the processor
//
// Purpose: groups the command port the sequencer owns while busy.
//   cmd_out    [7:0]  command byte
//   data_out   [23:0] data word for the command
//   cmd_strobe        one-cycle pulse per command (drives sipo_done)
//   status_in  [23:0] processor statusOut, valid one clock after a strobe
// master: the sequencer; slave: the processor side.
interface drive_move_sequencer_if;
    logic [7:0]  cmd_out;
    logic [23:0] data_out;
    logic        cmd_strobe;
    logic [23:0] status_in;

    modport master (
        output cmd_out,
        output data_out,
        output cmd_strobe,
        input  status_in
    );

    modport slave (
        input  cmd_out,
        input  data_out,
        input  cmd_strobe,
        output status_in
    );
endinterface

// File: rtl/drive_move_sequencer.sv
// rtl/drive_move_sequencer.sv - autonomous move controller driving the vehicle command port
//
// Purpose: on start, writes duty/direction to motors 1..4, polls one wheel's
// pulse-count distance every POLL_INTERVAL clocks, and writes zero duty to all
// four motors when the target is reached, on abort, or after MAX_POLLS polls.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle move request, sampled only in IDLE
//   abort               level, forces the stop sequence during a move
//   target_dist [23:0]  distance that ends the move (captured on start)
//   duty [7:0]          duty for all motors (captured on start)
//   dir [3:0]           bit n-1 = direction of motor n (captured on start)
//   wheel_sel [1:0]     wheel polled, CMD 0x01..0x04 (captured on start)
//   cmd_if              command port (cmd_out/data_out/cmd_strobe/status_in)
//   busy                move in progress; the top level muxes the port here
//   done                one-cycle pulse when the stop sequence completes
//   timed_out, aborted  sticky end-of-move reasons, cleared by the next start
//   last_dist [23:0]    most recently captured status_in
module drive_move_sequencer #(
    parameter int POLL_INTERVAL = 1000,
    parameter int MAX_POLLS     = 65535,
    parameter int POLL_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [23:0]                   target_dist,
    input  logic [7:0]                    duty,
    input  logic [3:0]                    dir,
    input  logic [1:0]                    wheel_sel,
    drive_move_sequencer_if.master        cmd_if,
    output logic                          busy,
    output logic                          done,
    output logic                          timed_out,
    output logic                          aborted,
    output logic [23:0]                   last_dist
);

    localparam int WAIT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POLL_INTERVAL - 1);
    localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(MAX_POLLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_SET,
        S_WAIT,
        S_POLL,
        S_CAPTURE,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          m_q, m_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [POLL_W-1:0]   polls_q, polls_d;
    logic [23:0]         target_q, target_d;
    logic [7:0]          duty_q, duty_d;
    logic [3:0]          dir_q, dir_d;
    logic [1:0]          wheel_q, wheel_d;
    logic [23:0]         last_q, last_d;
    logic                timed_q, timed_d;
    logic                aborted_q, aborted_d;
    logic                done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            wait_q    <= '0;
            polls_q   <= '0;
            target_q  <= '0;
            duty_q    <= '0;
            dir_q     <= '0;
            wheel_q   <= '0;
            last_q    <= '0;
            timed_q   <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            wait_q    <= wait_d;
            polls_q   <= polls_d;
            target_q  <= target_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            wheel_q   <= wheel_d;
            last_q    <= last_d;
            timed_q   <= timed_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        m_d               = m_q;
        wait_d            = wait_q;
        polls_d           = polls_q;
        target_d          = target_q;
        duty_d            = duty_q;
        dir_d             = dir_q;
        wheel_d           = wheel_q;
        last_d            = last_q;
        timed_d           = timed_q;
        aborted_d         = aborted_q;
        done_d            = 1'b0;
        cmd_if.cmd_out    = 8'h00;
        cmd_if.data_out   = 24'h000000;
        cmd_if.cmd_strobe = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    target_d  = target_dist;
                    duty_d    = duty;
                    dir_d     = dir;
                    wheel_d   = wheel_sel;
                    timed_d   = 1'b0;
                    aborted_d = 1'b0;
                    polls_d   = '0;
                    m_d       = 2'd0;
                    state_d   = S_RUN_SET;
                end
            end

            S_RUN_SET: begin
                cmd_if.cmd_strobe = 1'b1;
                cmd_if.cmd_out    = 8'h31 + {6'b0, m_q};
                cmd_if.data_out   = {15'b0, dir_q[m_q], duty_q};
                if (abort) begin
                    // The write in this cycle still goes out; the stop writes follow.
                    aborted_d = 1'b1;
                    m_d       = 2'd0;
                    state_d   = S_STOP;
                end else if (m_q == 2'd3) begin
                    m_d     = 2'd0;
                    wait_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    m_d = m_q + 2'd1;
                end
            end

            S_WAIT: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    m_d       = 2'd0;
                    state_d   = S_STOP;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_POLL;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_POLL: begin
                cmd_if.cmd_strobe = 1'b1;
                cmd_if.cmd_out    = 8'h01 + {6'b0, wheel_q};
                polls_d           = polls_q + 1'b1;
                if (abort) begin
                    aborted_d = 1'b1;
                    m_d       = 2'd0;
                    state_d   = S_STOP;
                end else begin
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                // The processor answers one clock after the poll strobe.
                last_d = cmd_if.status_in;
                m_d    = 2'd0;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_STOP;
                end else if (cmd_if.status_in >= target_q) begin
                    state_d = S_STOP;
                end else if (polls_q == POLL_LIMIT) begin
                    timed_d = 1'b1;
                    state_d = S_STOP;
                end else begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end

            S_STOP: begin
                // abort is ignored here so every motor always gets its zero-duty write.
                cmd_if.cmd_strobe = 1'b1;
                cmd_if.cmd_out    = 8'h31 + {6'b0, m_q};
                cmd_if.data_out   = {15'b0, dir_q[m_q], 8'h00};
                if (m_q == 2'd3) begin
                    m_d     = 2'd0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    m_d = m_q + 2'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign timed_out = timed_q;
    assign aborted   = aborted_q;
    assign last_dist = last_q;

endmodule

// File: tb/tb_drive_move_sequencer.sv
// tb/tb_drive_move_sequencer.sv - self-checking bench for drive_move_sequencer
module tb_drive_move_sequencer;

    localparam int PI = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, abort;
    logic [23:0] target;
    logic [7:0]  duty;
    logic [3:0]  dir;
    logic [1:0]  wheel;
    logic        busy_a, done_a, to_a, ab_a;
    logic        busy_b, done_b, to_b, ab_b;
    logic [23:0] last_a, last_b;

    drive_move_sequencer_if if_a ();
    drive_move_sequencer_if if_b ();

    drive_move_sequencer #(.POLL_INTERVAL(PI), .MAX_POLLS(65535), .POLL_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .target_dist(target),
        .duty(duty), .dir(dir), .wheel_sel(wheel), .cmd_if(if_a), .busy(busy_a),
        .done(done_a), .timed_out(to_a), .aborted(ab_a), .last_dist(last_a));

    drive_move_sequencer #(.POLL_INTERVAL(PI), .MAX_POLLS(3), .POLL_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .target_dist(target),
        .duty(duty), .dir(dir), .wheel_sel(wheel), .cmd_if(if_b), .busy(busy_b),
        .done(done_b), .timed_out(to_b), .aborted(ab_b), .last_dist(last_b));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0, nerr = 0;
    int cur = 0, c0 = 0;
    int st_base = 0, st_step = 0;
    int pc_a = 0, pc_b = 0;
    logic [63:0] act_q[$];
    logic [63:0] exp_q[$];
    int busy_cnt, done_cnt, done_rel, idle_bad;
    logic [23:0] mlast[2];
    int m_done, m_polls;
    bit m_to, m_ab;
    logic [23:0] m_last;

    // Processor stand-in: each poll returns base + k*step for the k-th poll of the move.
    always @(negedge clk) begin
        if (rst || !busy_a) begin
            pc_a = 0;
            if (rst) if_a.status_in = 24'h0;
        end else if (if_a.cmd_strobe && if_a.cmd_out >= 8'h01 && if_a.cmd_out <= 8'h04) begin
            if_a.status_in = 24'(st_base + pc_a * st_step);
            pc_a++;
        end
        if (rst || !busy_b) begin
            pc_b = 0;
            if (rst) if_b.status_in = 24'h0;
        end else if (if_b.cmd_strobe && if_b.cmd_out >= 8'h01 && if_b.cmd_out <= 8'h04) begin
            if_b.status_in = 24'(st_base + pc_b * st_step);
            pc_b++;
        end
    end

    // Monitor of the DUT selected by cur: strobe log stamped relative to the start cycle.
    always @(negedge clk) begin
        logic s, b, dn;
        logic [7:0] c;
        logic [23:0] d;
        s  = cur ? if_b.cmd_strobe : if_a.cmd_strobe;
        c  = cur ? if_b.cmd_out : if_a.cmd_out;
        d  = cur ? if_b.data_out : if_a.data_out;
        b  = cur ? busy_b : busy_a;
        dn = cur ? done_b : done_a;
        if (s) act_q.push_back({32'(cyc - c0), c, d});
        if (b) busy_cnt++;
        if (dn) begin
            if (done_cnt == 0) done_rel = cyc - c0;
            done_cnt++;
        end
        if (!if_a.cmd_strobe && (if_a.cmd_out != 8'h0 || if_a.data_out != 24'h0)) idle_bad++;
        if (!if_b.cmd_strobe && (if_b.cmd_out != 8'h0 || if_b.data_out != 24'h0)) idle_bad++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Timeline of one move built from the move rules: cycle 0 is the cycle start is high.
    task automatic model_move(input int sel, input logic [7:0] du, input logic [3:0] di,
                              input logic [1:0] wh, input logic [23:0] tg, input int base,
                              input int step, input int ab);
        int t, n, mp;
        bit fin;
        logic [23:0] st;
        mp = (sel == 1) ? 3 : 65535;
        exp_q.delete();
        m_to = 0; m_ab = 0; m_last = mlast[sel]; n = 0; t = 1; fin = 0;
        for (int m = 0; m < 4 && !fin; m++) begin
            exp_q.push_back({32'(t), 8'(8'h31 + m), 15'b0, di[m], du});
            fin = (ab >= 0 && t >= ab);
            t++;
        end
        m_ab = fin;
        while (!fin) begin
            for (int k = 0; k < PI && !fin; k++) begin
                fin = (ab >= 0 && t >= ab);
                t++;
            end
            if (fin) begin m_ab = 1; break; end
            exp_q.push_back({32'(t), 8'(8'h01 + wh), 24'h0});
            n++;
            fin = (ab >= 0 && t >= ab);
            t++;
            if (fin) begin m_ab = 1; break; end
            st = 24'(base + (n - 1) * step);
            m_last = st;
            if (ab >= 0 && t >= ab) begin m_ab = 1; fin = 1; end
            else if (st >= tg) fin = 1;
            else if (n == mp) begin m_to = 1; fin = 1; end
            t++;
        end
        for (int m = 0; m < 4; m++) begin
            exp_q.push_back({32'(t), 8'(8'h31 + m), 15'b0, di[m], 8'h00});
            t++;
        end
        m_done = t;
        m_polls = n;
    endtask

    task automatic run_move(input int sel, input logic [7:0] du, input logic [3:0] di,
                            input logic [1:0] wh, input logic [23:0] tg, input int base,
                            input int step, input int ab, input int rs, input int e_done,
                            input int e_polls, input bit e_to, input bit e_ab,
                            input logic [23:0] e_last, input string tag);
        int rel, n, polls;
        model_move(sel, du, di, wh, tg, base, step, ab);
        @(negedge clk);
        cur = sel; c0 = cyc;
        act_q.delete(); busy_cnt = 0; done_cnt = 0; done_rel = -1; idle_bad = 0;
        duty = du; dir = di; wheel = wh; target = tg; st_base = base; st_step = step;
        start_a = (sel == 0); start_b = (sel == 1);
        abort = (ab == 0);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            rel = cyc - c0;
            start_a = (sel == 0 && rel == rs);
            start_b = (sel == 1 && rel == rs);
            if (ab >= 0 && rel >= ab) abort = 1'b1;
            if (rel == 1) chk({tag, " flags_clear_on_start"}, sel ? {to_b, ab_b} : {to_a, ab_a}, 2'b00);
            n++;
        end
        abort = 1'b0; start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        chk({tag, " done_seen"}, (done_cnt > 0), 1);
        chk({tag, " strobe_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            chk({tag, " strobe{rel,cmd,data}"}, act_q[i], exp_q[i]);
        polls = 0;
        foreach (act_q[i]) if (act_q[i][31:24] >= 8'h01 && act_q[i][31:24] <= 8'h04) polls++;
        chk({tag, " done_rel"}, done_rel, e_done);
        chk({tag, " done_pulses"}, done_cnt, 1);
        chk({tag, " polls"}, polls, e_polls);
        chk({tag, " busy_cycles"}, busy_cnt, e_done - 1);
        chk({tag, " timed_out"}, sel ? to_b : to_a, e_to);
        chk({tag, " aborted"}, sel ? ab_b : ab_a, e_ab);
        chk({tag, " last_dist"}, sel ? last_b : last_a, e_last);
        chk({tag, " idle_port_zero"}, idle_bad, 0);
        mlast[sel] = m_last;
    endtask

    typedef struct {
        int sel; logic [7:0] du; logic [3:0] di; logic [1:0] wh; logic [23:0] tg;
        int base; int step; int ab; int rs;
        int e_done; int e_polls; bit e_to; bit e_ab; logic [23:0] e_last;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{0, 8'h40, 4'b0101, 2'd0, 24'd100,  30, 30, -1, -1, 33, 4, 1'b0, 1'b0, 24'd120};
        vecs[1] = '{0, 8'h80, 4'b1010, 2'd1, 24'd0,     7,  1, -1, -1, 15, 1, 1'b0, 1'b0, 24'd7};
        vecs[2] = '{1, 8'h22, 4'b1111, 2'd3, 24'd1000,  5,  0, -1, -1, 27, 3, 1'b1, 1'b0, 24'd5};
        vecs[3] = '{0, 8'h55, 4'b0011, 2'd2, 24'd1000, 10, 10, 18, 12, 23, 2, 1'b0, 1'b1, 24'd20};
        vecs[4] = '{0, 8'h66, 4'b1001, 2'd0, 24'd50,    0,  1,  0, -1,  6, 0, 1'b0, 1'b1, 24'd20};
        vecs[5] = '{0, 8'h10, 4'b0110, 2'd1, 24'd10,   50,  0, 10, -1, 15, 1, 1'b0, 1'b1, 24'd50};
        vecs[6] = '{0, 8'h01, 4'b0000, 2'd2, 24'd25,    0, 10, -1, -1, 33, 4, 1'b0, 1'b0, 24'd30};
        vecs[7] = '{0, 8'h7f, 4'b1100, 2'd3, 24'd5,     1,  1,  2, -1,  7, 0, 1'b0, 1'b1, 24'd30};
        vecs[8] = '{1, 8'h33, 4'b0101, 2'd1, 24'd9,     1,  4, -1, -1, 27, 3, 1'b0, 1'b0, 24'd9};

        rst = 1'b1; start_a = 0; start_b = 0; abort = 0;
        target = 0; duty = 0; dir = 0; wheel = 0;
        mlast[0] = 0; mlast[1] = 0;
        repeat (3) @(negedge clk);
        chk("reset busy", {busy_a, busy_b}, 2'b00);
        chk("reset done", {done_a, done_b}, 2'b00);
        chk("reset flags", {to_a, ab_a, to_b, ab_b}, 4'b0000);
        chk("reset port", {if_a.cmd_strobe, if_a.cmd_out, if_a.data_out}, 33'h0);
        chk("reset last_dist", last_a, 24'h0);
        rst = 1'b0;

        // Reset in the middle of WAIT clears outputs at once.
        @(negedge clk);
        c0 = cyc; duty = 8'h40; dir = 4'b0101; target = 24'hFFFFFF; st_base = 0; st_step = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("midwait busy", busy_a, 1'b1);
        rst = 1'b1;
        #1;
        chk("midwait reset busy", busy_a, 1'b0);
        chk("midwait reset strobe", {if_a.cmd_strobe, if_a.cmd_out}, 9'h0);
        chk("midwait reset done", done_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("post reset flags", {to_a, ab_a, last_a}, 26'h0);

        for (int i = 0; i < 9; i++)
            run_move(vecs[i].sel, vecs[i].du, vecs[i].di, vecs[i].wh, vecs[i].tg,
                     vecs[i].base, vecs[i].step, vecs[i].ab, vecs[i].rs, vecs[i].e_done,
                     vecs[i].e_polls, vecs[i].e_to, vecs[i].e_ab, vecs[i].e_last,
                     $sformatf("vec%0d", i));

        for (int r = 0; r < 12; r++) begin
            logic [7:0] du; logic [3:0] di; logic [1:0] wh; logic [23:0] tg;
            int base, step, ab;
            du = 8'($urandom); di = 4'($urandom); wh = 2'($urandom);
            tg = 24'($urandom_range(0, 400));
            base = int'($urandom_range(0, 50));
            step = int'($urandom_range(20, 60));
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : -1;
            model_move(0, du, di, wh, tg, base, step, ab);
            run_move(0, du, di, wh, tg, base, step, ab, -1, m_done, m_polls, m_to, m_ab,
                     m_last, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
